// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional build macro: REGFILE_MP_BYPASS_EN (write-through forwarding).
package regfile_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_wsel.sv
// Priority resolver: picks the highest-index valid write port
// matching one address and flags multiple hits.
module regfile_mp_wsel #(
  parameter int NUM_W = 4,
  parameter int WIDTH = 65,
  parameter int AW    = 7
) (
  input  logic [AW-1:0]          i_idx,
  input  logic [NUM_W-1:0]       i_vld,
  input  logic [NUM_W*AW-1:0]    i_addr,
  input  logic [NUM_W*WIDTH-1:0] i_data,
  output logic                   o_hit,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_conf
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    o_conf = 1'b0;
    for (int p = 0; p < NUM_W; p++) begin
      if (i_vld[p] && (i_addr[p*AW +: AW] == i_idx)) begin
        o_conf = o_conf | o_hit;
        o_hit  = 1'b1;
        o_data = i_data[p*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_init.sv
// Multi-read/multi-write register file with post-reset clear sequencer.
// Optional build macro: REGFILE_MP_BYPASS_EN (write-through forwarding).
module regfile_mp_init
  import regfile_mp_pkg::*;
#(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 65,
  parameter  int NUM_R = 6,
  parameter  int NUM_W = 4,
  localparam int AW    = rf_addr_w(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_R-1:0]       r_en,
  input  logic [NUM_R*AW-1:0]    r_addr,
  output logic [NUM_R*WIDTH-1:0] r_data,
  input  logic [NUM_W-1:0]       w_en,
  input  logic [NUM_W*AW-1:0]    w_addr,
  input  logic [NUM_W*WIDTH-1:0] w_data,
  output logic                   ready,
  output logic                   conflict,
  input  logic                   conflict_clr
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  rf_state_e        r_state;
  rf_state_e        w_state_nxt;
  logic [AW-1:0]    r_clr_idx;
  logic [AW-1:0]    w_clr_nxt;
  logic             r_conflict;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [NUM_W-1:0] w_wvld;
  logic [DEPTH-1:0] w_we;
  logic [DEPTH-1:0] w_econf;
  logic [WIDTH-1:0] w_wd [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_idx;
    unique case (r_state)
      CLEAR: begin
        w_clr_nxt = r_clr_idx + AW'(1);
        if (r_clr_idx == LAST)
          w_state_nxt = READY;
      end
      READY: w_state_nxt = READY;
    endcase
  end

  always_comb begin
    ready = (r_state == READY);
  end

  // A write port counts only when ready and its address is in range.
  for (genvar p = 0; p < NUM_W; p++) begin : g_wvld
    assign w_wvld[p] = ready & w_en[p]
      & ({1'b0, w_addr[p*AW +: AW]} < DEPTH_W);
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    regfile_mp_wsel #(
      .NUM_W (NUM_W),
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_wsel (
      .i_idx  (AW'(e)),
      .i_vld  (w_wvld),
      .i_addr (w_addr),
      .i_data (w_data),
      .o_hit  (w_we[e]),
      .o_data (w_wd[e]),
      .o_conf (w_econf[e])
    );
  end

  always_ff @(posedge clock) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_we[e])
          r_mem[e] <= w_wd[e];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_conflict <= 1'b0;
    else if (|w_econf)
      r_conflict <= 1'b1;
    else if (conflict_clr)
      r_conflict <= 1'b0;
  end

  assign conflict = r_conflict;

  for (genvar i = 0; i < NUM_R; i++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic             w_rok;
    logic [WIDTH-1:0] w_rmem;

    assign w_ra   = r_addr[i*AW +: AW];
    assign w_rok  = r_en[i] & ({1'b0, w_ra} < DEPTH_W);
    assign w_rmem = w_rok ? r_mem[w_ra] : '0;

`ifdef REGFILE_MP_BYPASS_EN
    logic             w_bhit;
    logic [WIDTH-1:0] w_bdat;

    regfile_mp_wsel #(
      .NUM_W (NUM_W),
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_byp (
      .i_idx  (w_ra),
      .i_vld  (w_wvld),
      .i_addr (w_addr),
      .i_data (w_data),
      .o_hit  (w_bhit),
      .o_data (w_bdat),
      .o_conf ()
    );

    assign r_data[i*WIDTH +: WIDTH] =
      (w_rok & w_bhit) ? w_bdat : w_rmem;
`else
    assign r_data[i*WIDTH +: WIDTH] = w_rmem;
`endif
  end

endmodule

// File: tb/tb_regfile_mp_init.sv
// Randomized self-checking bench for regfile_mp_init (default and
// DEPTH=100 instances); honours REGFILE_MP_BYPASS_EN.
module tb_regfile_mp_init;

  localparam int D   = 128;
  localparam int W   = 65;
  localparam int NR  = 6;
  localparam int NW  = 4;
  localparam int AW  = 7;
  localparam int D2  = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    r_en;
  logic [NR*AW-1:0] r_addr;
  logic [NR*W-1:0]  r_data;
  logic [NW-1:0]    w_en;
  logic [NW*AW-1:0] w_addr;
  logic [NW*W-1:0]  w_data;
  logic             ready;
  logic             conflict;
  logic             conflict_clr;

  logic [NR-1:0]    s_r_en;
  logic [NR*AW-1:0] s_r_addr;
  logic [NR*W-1:0]  s_r_data;
  logic [NW-1:0]    s_w_en;
  logic [NW*AW-1:0] s_w_addr;
  logic [NW*W-1:0]  s_w_data;
  logic             s_ready;
  logic             s_conflict;
  logic             s_conflict_clr;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  int           m_cnt;
  bit           m_conf;

  always #5 clk = ~clk;

  regfile_mp_init u_dut (
    .clock        (clk),
    .reset        (rst),
    .r_en         (r_en),
    .r_addr       (r_addr),
    .r_data       (r_data),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .ready        (ready),
    .conflict     (conflict),
    .conflict_clr (conflict_clr)
  );

  regfile_mp_init #(.DEPTH(D2)) u_d100 (
    .clock        (clk),
    .reset        (rst),
    .r_en         (s_r_en),
    .r_addr       (s_r_addr),
    .r_data       (s_r_data),
    .w_en         (s_w_en),
    .w_addr       (s_w_addr),
    .w_data       (s_w_data),
    .ready        (s_ready),
    .conflict     (s_conflict),
    .conflict_clr (s_conflict_clr)
  );

  function automatic bit m_ready();
    return !rst && (m_cnt >= D);
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Expected combinational read of port i from the spec rules.
  function automatic logic [W-1:0] exp_rd(input int i);
    int a;
    a = int'(r_addr[i*AW +: AW]);
    if (!r_en[i]) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    if (m_ready()) begin
      for (int p = NW - 1; p >= 0; p--)
        if (w_en[p] && int'(w_addr[p*AW +: AW]) == a)
          return w_data[p*W +: W];
    end
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_known(input int i);
    return !r_en[i] || m_known[int'(r_addr[i*AW +: AW])];
  endfunction

  task automatic set_w(input int p, input int a, input logic [W-1:0] d);
    w_addr[p*AW +: AW] = AW'(a);
    w_data[p*W +: W]   = d;
  endtask

  task automatic set_r(input int i, input int a);
    r_addr[i*AW +: AW] = AW'(a);
  endtask

  // Advance one clock; the model applies the spec's edge rules.
  task automatic step();
    logic [D-1:0] seen;
    bit hit;
    int a;
    seen = '0;
    hit  = 1'b0;
    if (rst) begin
      m_cnt  = 0;
      m_conf = 1'b0;
    end else if (m_cnt < D) begin
      m_mem[m_cnt]   = '0;
      m_known[m_cnt] = 1'b1;
      m_cnt++;
    end else begin
      for (int p = 0; p < NW; p++) begin
        a = int'(w_addr[p*AW +: AW]);
        if (w_en[p] && a < D) begin
          if (seen[a]) hit = 1'b1;
          seen[a]  = 1'b1;
          m_mem[a] = w_data[p*W +: W];
        end
      end
    end
    if (!rst)
      m_conf = hit ? 1'b1 : (conflict_clr ? 1'b0 : m_conf);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    r_en = '0; r_addr = '0; w_en = '0; w_addr = '0; w_data = '0;
    conflict_clr = 1'b0;
    s_r_en = '0; s_r_addr = '0; s_w_en = '0; s_w_addr = '0;
    s_w_data = '0; s_conflict_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    w_en = '0;
    r_en = '1;
    for (int a = 0; a < D; a += NR) begin
      for (int i = 0; i < NR; i++) set_r(i, (a + i) % D);
      #1;
      for (int i = 0; i < NR; i++) begin
        checks++;
        if (r_data[i*W +: W] !== '0) begin
          errors++;
          $display("FAIL %s port%0d addr%0d: got %h want 0",
                   tag, i, (a + i) % D, r_data[i*W +: W]);
        end
      end
    end
    r_en = '0;
  endtask

  task automatic release_and_clear(input string tag, input bit noise);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 1; k <= D; k++) begin
      if (noise) begin
        w_en = NW'($urandom);
        for (int p = 0; p < NW; p++) set_w(p, $urandom_range(D - 1), rnd_data());
      end
      step();
      checks++;
      if (ready !== (k >= D)) begin
        errors++;
        $display("FAIL %s ready@%0d: got %b want %b", tag, k, ready, k >= D);
      end
      if (k == D2 - 1 || k == D2) begin
        checks++;
        if (s_ready !== (k >= D2)) begin
          errors++;
          $display("FAIL %s d100 ready@%0d: got %b want %b",
                   tag, k, s_ready, k >= D2);
        end
      end
    end
    w_en = '0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    m_cnt = 0;
    m_conf = 1'b0;
    for (int a = 0; a < D; a++) m_known[a] = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b conflict=%b want 0 0",
               ready, conflict);
    end
    step();
    step();
    release_and_clear("reset", 1'b0);
    check_all_zero("reset_clear");
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_conflict: got %b want 0", conflict);
    end
  endtask

  task automatic test_conflict();
    quiet();
    set_w(0, 5, 65'h1_2345_6789_ABCD_EF01);
    set_w(3, 5, 65'h7);
    w_en = 4'b1001;
    step();
    w_en = '0;
    r_en[0] = 1'b1;
    set_r(0, 5);
    #1;
    checks++;
    if (r_data[0 +: W] !== 65'h7) begin
      errors++;
      $display("FAIL conflict_prio: got %h want 7", r_data[0 +: W]);
    end
    checks++;
    if (conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_set: got %b want 1", conflict);
    end
    conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict_clr: got %b want 0", conflict);
    end
    set_w(1, 6, rnd_data());
    set_w(2, 6, rnd_data());
    w_en = 4'b0110;
    conflict_clr = 1'b1;
    step();
    w_en = '0;
    conflict_clr = 1'b0;
    checks++;
    if (conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_set_wins: got %b want 1", conflict);
    end
    quiet();
  endtask

  task automatic test_dual();
    logic [W-1:0] da, db;
    quiet();
    da = rnd_data();
    db = ~da;
    set_w(1, 127, da);
    set_w(2, 0, db);
    w_en = 4'b0110;
    step();
    w_en = '0;
    r_en = 6'b110000;
    for (int i = 0; i < NR; i++) set_r(i, 127);
    set_r(5, 0);
    #1;
    checks++;
    if (r_data[4*W +: W] !== da) begin
      errors++;
      $display("FAIL dual_r4: got %h want %h", r_data[4*W +: W], da);
    end
    checks++;
    if (r_data[5*W +: W] !== db) begin
      errors++;
      $display("FAIL dual_r5: got %h want %h", r_data[5*W +: W], db);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r_data[i*W +: W] !== '0) begin
        errors++;
        $display("FAIL rd_disabled p%0d: got %h want 0", i, r_data[i*W +: W]);
      end
    end
    quiet();
  endtask

  task automatic test_random();
    quiet();
    for (int n = 0; n < 300; n++) begin
      r_en = NR'($urandom);
      for (int i = 0; i < NR; i++)
        set_r(i, ($urandom % 2) ? $urandom_range(15) : $urandom_range(D - 1));
      w_en = NW'($urandom);
      for (int p = 0; p < NW; p++) set_w(p, $urandom_range(15), rnd_data());
      conflict_clr = ($urandom % 4 == 0);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (exp_known(i)) begin
          checks++;
          if (r_data[i*W +: W] !== exp_rd(i)) begin
            errors++;
            $display("FAIL rand_rd n%0d p%0d: got %h want %h",
                     n, i, r_data[i*W +: W], exp_rd(i));
          end
        end
      end
      step();
      checks++;
      if (conflict !== m_conf) begin
        errors++;
        $display("FAIL rand_conflict n%0d: got %b want %b", n, conflict, m_conf);
      end
    end
    quiet();
  endtask

  task automatic test_reset_midclear();
    quiet();
    set_w(0, 3, rnd_data());
    set_w(1, 3, rnd_data());
    w_en = 4'b0011;
    step();
    w_en = '0;
    rst = 1'b1;
    m_cnt = 0;
    m_conf = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL midclr_rst: got ready=%b conflict=%b want 0 0",
               ready, conflict);
    end
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 1; k <= 50; k++) begin
      w_en = NW'($urandom);
      for (int p = 0; p < NW; p++) set_w(p, $urandom_range(D - 1), rnd_data());
      step();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL midclr_ready@%0d: got %b want 0", k, ready);
      end
    end
    w_en = '0;
    rst = 1'b1;
    m_cnt = 0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midclr_pulse: got %b want 0", ready);
    end
    step();
    release_and_clear("midclr", 1'b1);
    check_all_zero("midclr_zero");
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL midclr_conflict: got %b want 0", conflict);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
    quiet();
    set_w(0, 9, 65'h55);
    w_en = 4'b0001;
    step();
    set_w(0, 0, '0);
    set_w(2, 9, 65'hAA);
    w_en = 4'b0100;
    r_en = 6'b000010;
    set_r(1, 9);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    want = 65'hAA;
`else
    want = 65'h55;
`endif
    checks++;
    if (r_data[W +: W] !== want) begin
      errors++;
      $display("FAIL bypass_same: got %h want %h", r_data[W +: W], want);
    end
    step();
    w_en = '0;
    #1;
    checks++;
    if (r_data[W +: W] !== 65'hAA) begin
      errors++;
      $display("FAIL bypass_next: got %h want aa", r_data[W +: W]);
    end
    quiet();
  endtask

  task automatic test_d100();
    logic [W-1:0] dy, want;
    quiet();
    dy = rnd_data() | 65'h1;
    s_w_addr[0*AW +: AW] = 7'd110;
    s_w_data[0*W +: W]   = rnd_data();
    s_w_addr[1*AW +: AW] = 7'd99;
    s_w_data[1*W +: W]   = dy;
    s_w_addr[2*AW +: AW] = 7'd110;
    s_w_data[2*W +: W]   = rnd_data();
    s_w_en = 4'b0111;
    s_r_en = 6'b000011;
    s_r_addr[0*AW +: AW] = 7'd110;
    s_r_addr[1*AW +: AW] = 7'd99;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    want = dy;
`else
    want = '0;
`endif
    checks++;
    if (s_r_data[0 +: W] !== '0) begin
      errors++;
      $display("FAIL d100_oor_same: got %h want 0", s_r_data[0 +: W]);
    end
    checks++;
    if (s_r_data[W +: W] !== want) begin
      errors++;
      $display("FAIL d100_99_same: got %h want %h", s_r_data[W +: W], want);
    end
    step();
    s_w_en = '0;
    #1;
    checks++;
    if (s_r_data[0 +: W] !== '0) begin
      errors++;
      $display("FAIL d100_oor: got %h want 0", s_r_data[0 +: W]);
    end
    checks++;
    if (s_r_data[W +: W] !== dy) begin
      errors++;
      $display("FAIL d100_99: got %h want %h", s_r_data[W +: W], dy);
    end
    checks++;
    if (s_conflict !== 1'b0) begin
      errors++;
      $display("FAIL d100_oor_conflict: got %b want 0", s_conflict);
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_dual();
    test_random();
    test_reset_midclear();
    test_bypass();
    test_d100();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
